// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Sequential instruction fetch unit.
//
// A PC register drives a synchronous instruction memory (one-cycle read
// latency). Returned words are queued with their byte PC in a 2-entry output
// FIFO. The consumer sees the FIFO head via a valid/ready handshake. At most
// two instructions are ever held or outstanding (FIFO entries plus the one
// read in flight), so the FIFO can never overflow.
//
// Optional feature (macro INSTR_FETCH_REDIRECT_EN):
//   defined   - redirect_valid flushes the FIFO, discards any in-flight read
//               and reloads the PC from redirect_pc (word aligned).
//   undefined - redirect_valid / redirect_pc are present but ignored.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset_n        in   synchronous active-low reset
//   redirect_valid in   load redirect_pc into the PC this cycle
//   redirect_pc    in   redirect target byte address
//   mem_read       out  read strobe to instruction memory
//   mem_address    out  word address (pc >> 2)
//   mem_data       in   read data, valid one cycle after mem_read
//   instr_valid    out  FIFO head is available
//   instr_ready    in   consumer accepts the head
//   instr_pc       out  byte PC of the head instruction (0 when empty)
//   instr_data     out  head instruction word (0 when empty)
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned              address_width = 16,
    parameter int unsigned              data_width    = 32,
    parameter logic [address_width-1:0] reset_pc      = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     redirect_valid,
    input  logic [address_width-1:0] redirect_pc,
    output logic                     mem_read,
    output logic [address_width-1:0] mem_address,
    input  logic [data_width-1:0]    mem_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [address_width-1:0] instr_pc,
    output logic [data_width-1:0]    instr_data
);

    logic [address_width-1:0] pc_q, pc_d;
    logic [address_width-1:0] inflight_pc_q, inflight_pc_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               count_q, count_d;
    logic [address_width-1:0] fifo_pc_q [2];
    logic [address_width-1:0] fifo_pc_d [2];
    logic [data_width-1:0]    fifo_data_q [2];
    logic [data_width-1:0]    fifo_data_d [2];

    logic                     redirect;
    logic [address_width-1:0] redirect_target;
    logic                     pop;
    logic                     issue;
    logic [2:0]               occupancy;

`ifdef INSTR_FETCH_REDIRECT_EN
    logic unused_redirect_lsbs;
    assign redirect             = redirect_valid;
    assign redirect_target      = {redirect_pc[address_width-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`else
    logic unused_redirect;
    assign redirect        = 1'b0;
    assign redirect_target = reset_pc;
    assign unused_redirect = ^{redirect_valid, redirect_pc};
`endif

    // Outputs are masked during the reset cycle so nothing is handed out or
    // requested while state is being cleared.
    always_comb begin
        instr_valid = reset_n && (count_q != 2'd0);
        pop         = instr_valid && instr_ready;
        // Entries held plus the one in flight, after this cycle's pop.
        occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = reset_n && !redirect && (occupancy < 3'd2);
        mem_read    = issue;
        mem_address = pc_q >> 2;
        instr_pc    = instr_valid ? fifo_pc_q[0]   : '0;
        instr_data  = instr_valid ? fifo_data_q[0] : '0;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;

        if (redirect) begin
            // Flush everything; the pending memory response is dropped by
            // clearing inflight so it never gets pushed.
            pc_d       = redirect_target;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d          = pc_q + address_width'(4);
                inflight_pc_d = pc_q;
            end

            // Push happens the cycle after issue, when mem_data is valid.
            unique case ({inflight_q, pop})
                2'b01: begin
                    fifo_pc_d[0]   = fifo_pc_q[1];
                    fifo_data_d[0] = fifo_data_q[1];
                    count_d        = count_q - 2'd1;
                end
                2'b10: begin
                    fifo_pc_d[count_q[0]]   = inflight_pc_q;
                    fifo_data_d[count_q[0]] = mem_data;
                    count_d                 = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifo_pc_d[0]   = inflight_pc_q;
                        fifo_data_d[0] = mem_data;
                    end else begin
                        fifo_pc_d[0]   = fifo_pc_q[1];
                        fifo_data_d[0] = fifo_data_q[1];
                        fifo_pc_d[1]   = inflight_pc_q;
                        fifo_data_d[1] = mem_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= reset_pc;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter address_width, default 16, byte-address and PC width.
REQ-002 SHALL have parameter data_width, default 32, instruction width.
REQ-003 SHALL have parameter reset_pc, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port redirect_valid  input  1  load a new PC this cycle.
REQ-007 SHALL have port redirect_pc  input  address_width  redirect target byte address.
REQ-008 SHALL have port mem_read  output  1  read strobe to synchronous instruction memory.
REQ-009 SHALL have port mem_address  output  address_width  word address, equal to pc >> 2.
REQ-010 SHALL have port mem_data  input  data_width  read data, valid exactly 1 cycle after mem_read.
REQ-011 SHALL have port instr_valid  output  1  head instruction available.
REQ-012 SHALL have port instr_ready  input  1  consumer accepts head.
REQ-013 SHALL have port instr_pc  output  address_width  byte PC of head instruction.
REQ-014 SHALL have port instr_data  output  data_width  head instruction word.

Function
REQ-015 SHALL hold a PC register, a 2-entry output FIFO of {pc, data}, an occupancy count (0..2) and an in-flight flag.
REQ-016 SHALL assert mem_read (issue) when no redirect and count + inflight - pop < 2, where pop = instr_valid & instr_ready.
REQ-017 SHALL advance PC by 4 on each issue, wrapping modulo 2^address_width.
REQ-018 SHALL set inflight on issue and push {issued pc, mem_data} into the FIFO the following cycle.
REQ-019 SHALL drive instr_valid = (count != 0); instr_pc/instr_data are the FIFO head, stable while instr_valid & !instr_ready.
REQ-020 SHALL pop the head on instr_valid & instr_ready; a simultaneous push and pop keeps count unchanged and preserves order.
REQ-021 SHALL sustain one instruction per cycle when instr_ready stays high; first instr_valid occurs 2 cycles after reset release.
REQ-022 SHALL never overflow: with instr_ready low, at most 2 reads are outstanding and mem_read then stays low.
REQ-023 On redirect_valid: flush FIFO (count 0), discard data of any in-flight read, load PC = redirect_pc with bits [1:0] forced to 0, and deassert mem_read in that cycle.
REQ-024 Redirect SHALL take priority over issue, push and pop in the same cycle; instr_valid is 0 the cycle after a redirect.
REQ-025 SHALL drive mem_address = pc >> 2 combinationally at all times; it is meaningful only when mem_read is 1.

Reset
REQ-026 When reset_n is 0 at a rising edge: PC = reset_pc, count = 0, inflight = 0.
REQ-027 During and after reset: instr_valid = 0, mem_read = 0 in the reset cycle; instr_pc = 0 and instr_data = 0 while count = 0.
REQ-028 Reset SHALL override redirect, issue and pop; a read in flight at reset is discarded.

Configuration
REQ-029 Macro INSTR_FETCH_REDIRECT_EN, defined: redirect_valid/redirect_pc behave per REQ-023/024.
REQ-030 Macro not defined: both ports remain present but are ignored; PC changes only by reset and sequential increment.

Verification
REQ-031 Memory word k = 32'hA000_0000 + k, reset_pc = 0, instr_ready = 1: mem_address 0,1,2,...; instr_pc 0x0000,0x0004,0x0008 with data A0000000,A0000001,A0000002; first valid 2 cycles after reset release; one per cycle thereafter.
REQ-032 instr_ready = 0 from reset: exactly two reads (addresses 0,1), then mem_read low; head holds pc 0x0000; raise instr_ready: pcs 0x0000,0x0004,0x0008,... with no loss or duplication.
REQ-033 Macro defined, redirect_valid for one cycle with redirect_pc = 0x0042 while a read is in flight: next mem_read shows mem_address 0x0010; instr_valid 0 the next cycle; first delivered instr_pc = 0x0040, data A0000010.
REQ-034 reset_pc = 0xFFFC: delivered pcs 0xFFFC, 0x0000, 0x0004; mem_address 0x3FFF, 0x0000, 0x0001.
REQ-035 Count = 2 with instr_ready low, assert reset_n = 0 for one cycle: instr_valid 0 the next cycle; next issue is at reset_pc.
REQ-036 Macro undefined, redirect_valid pulsed with 0x0040: delivered pc sequence continues 0x0000,0x0004,... unaffected.
